// File: rtl/regfile_wr_buffer.sv
// In-order write-back buffer feeding the 32x32 register file write port.
// Drains one entry per cycle and offers youngest-match bypass for two read indices.
module regfile_wr_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [AW-1:0]            in_addr,
   input  logic [DW-1:0]            in_data,
   input  logic                     drain_en,
   output logic                     RegWrite,
   output logic [AW-1:0]            regW,
   output logic [DW-1:0]            Wdat,
   input  logic [AW-1:0]            regA,
   input  logic [AW-1:0]            regB,
   output logic                     hitA,
   output logic                     hitB,
   output logic [DW-1:0]            fwdA,
   output logic [DW-1:0]            fwdB,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] addr_r  [DEPTH];
   logic [DW-1:0] data_r  [DEPTH];
   logic          valid_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;

   logic          push_s;
   logic          pop_s;
   logic          empty_s;
   logic          ready_s;
   logic [PW-1:0] scan_idx_s [DEPTH];
   logic          hit_a_s;
   logic          hit_b_s;
   logic [DW-1:0] fwd_a_s;
   logic [DW-1:0] fwd_b_s;

   assign empty_s = (count_r == {CW{1'b0}});
   assign ready_s = (count_r != CW'(DEPTH));
   assign push_s  = in_valid && ready_s;
   assign pop_s   = drain_en && !empty_s;

   assign in_ready = ready_s;
   assign empty    = empty_s;
   assign count    = count_r;
   assign RegWrite = pop_s;
   assign regW     = empty_s ? {AW{1'b0}} : addr_r[rd_ptr_r];
   assign Wdat     = empty_s ? {DW{1'b0}} : data_r[rd_ptr_r];
   assign hitA     = hit_a_s;
   assign hitB     = hit_b_s;
   assign fwdA     = fwd_a_s;
   assign fwdB     = fwd_b_s;

   // scan_idx_s[0] is the oldest slot, scan_idx_s[DEPTH-1] the youngest possible slot
   for (genvar g = 0; g < DEPTH; g++) begin : g_scan
      assign scan_idx_s[g] = rd_ptr_r + PW'(g);
   end

   // Bypass lookup: walk oldest to youngest so the last match seen is the youngest
   always_comb begin
      hit_a_s = 1'b0;
      hit_b_s = 1'b0;
      fwd_a_s = {DW{1'b0}};
      fwd_b_s = {DW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         hit_a_s = hit_a_s | (valid_r[scan_idx_s[i]] && (addr_r[scan_idx_s[i]] == regA));
         hit_b_s = hit_b_s | (valid_r[scan_idx_s[i]] && (addr_r[scan_idx_s[i]] == regB));
         fwd_a_s = (valid_r[scan_idx_s[i]] && (addr_r[scan_idx_s[i]] == regA)) ?
                   data_r[scan_idx_s[i]] : fwd_a_s;
         fwd_b_s = (valid_r[scan_idx_s[i]] && (addr_r[scan_idx_s[i]] == regB)) ?
                   data_r[scan_idx_s[i]] : fwd_b_s;
      end
   end

   // FIFO storage, pointers and occupancy; a pop never targets the slot being pushed
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            addr_r[i]  <= {AW{1'b0}};
            data_r[i]  <= {DW{1'b0}};
            valid_r[i] <= 1'b0;
         end
      end else begin
         if (pop_s) begin
            valid_r[rd_ptr_r] <= 1'b0;
            rd_ptr_r          <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         end else begin
            rd_ptr_r          <= rd_ptr_r;
         end
         if (push_s) begin
            addr_r[wr_ptr_r]  <= in_addr;
            data_r[wr_ptr_r]  <= in_data;
            valid_r[wr_ptr_r] <= 1'b1;
            wr_ptr_r          <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
         end else begin
            wr_ptr_r          <= wr_ptr_r;
         end
         count_r <= count_r + CW'(push_s) - CW'(pop_s);
      end
   end

endmodule

// File: tb/tb_regfile_wr_buffer.sv
// Scenario bench for regfile_wr_buffer: a queue of expected writes is filled as
// pushes are accepted and drained as the write port fires.
module tb_regfile_wr_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] in_addr = '0;
   logic [DW-1:0] in_data = '0;
   logic          drain_en = 1'b0;
   logic          RegWrite;
   logic [AW-1:0] regW;
   logic [DW-1:0] Wdat;
   logic [AW-1:0] regA = '0;
   logic [AW-1:0] regB = '0;
   logic          hitA, hitB;
   logic [DW-1:0] fwdA, fwdB;
   logic [CW-1:0] count;
   logic          empty;

   logic [AW+DW-1:0] exp_q[$];
   int mdl_count = 0;
   int vectors = 0;
   int miscompares = 0;

   regfile_wr_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .drain_en(drain_en),
      .RegWrite(RegWrite), .regW(regW), .Wdat(Wdat),
      .regA(regA), .regB(regB), .hitA(hitA), .hitB(hitB),
      .fwdA(fwdA), .fwdB(fwdB), .count(count), .empty(empty)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running, required completion");
      $fatal(1);
   end

   // One cycle: check the write port at the falling edge, then model the rising edge.
   task automatic tick();
      logic [AW+DW-1:0] e;
      logic acc, pp;
      @(negedge clk);
      if (rst) begin
         vectors++;
         if (RegWrite !== (drain_en && exp_q.size() != 0)) begin
            miscompares++;
            $display("FAIL regwrite_strobe: got %b required %b", RegWrite, (drain_en && exp_q.size() != 0));
         end else if (RegWrite) begin
            e = exp_q.pop_front();
            vectors++;
            if ({regW, Wdat} !== e) begin
               miscompares++;
               $display("FAIL write_order: got %0d/%h required %0d/%h", regW, Wdat, e[AW+DW-1:DW], e[DW-1:0]);
            end
         end
      end
      @(posedge clk);
      if (rst) begin
         acc = in_valid && (mdl_count != DEPTH);
         pp  = drain_en && (mdl_count != 0);
         if (acc) exp_q.push_back({in_addr, in_data});
         mdl_count = mdl_count + int'(acc) - int'(pp);
      end
      #1;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      vectors++;
      if ({in_ready, empty, RegWrite, hitA, hitB} !== 5'b11000) begin
         miscompares++;
         $display("FAIL reset_flags: got %b required 11000", {in_ready, empty, RegWrite, hitA, hitB});
      end
      vectors++;
      if ({count, regW, Wdat, fwdA, fwdB} !== '0) begin
         miscompares++;
         $display("FAIL reset_values: count=%0d regW=%0d Wdat=%h fwdA=%h fwdB=%h required all 0", count, regW, Wdat, fwdA, fwdB);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single();
      drain_en = 1'b1;
      push(5'd3, 32'h0000_00AA);
      vectors++;
      if ({RegWrite, regW, Wdat} !== {1'b1, 5'd3, 32'h0000_00AA}) begin
         miscompares++;
         $display("FAIL single_port: got %b/%0d/%h required 1/3/000000aa", RegWrite, regW, Wdat);
      end
      tick();
      vectors++;
      if ({empty, RegWrite} !== 2'b10) begin
         miscompares++;
         $display("FAIL single_drained: got empty=%b RegWrite=%b required 1/0", empty, RegWrite);
      end
   endtask

   task automatic test_full();
      drain_en = 1'b0;
      push(5'd1, 32'h11);
      push(5'd2, 32'h22);
      push(5'd1, 32'h33);
      push(5'd5, 32'h55);
      vectors++;
      if ({count, in_ready} !== {3'd4, 1'b0}) begin
         miscompares++;
         $display("FAIL full_state: got count=%0d in_ready=%b required 4/0", count, in_ready);
      end
      push(5'd9, 32'h99);
      vectors++;
      if (count !== 3'd4) begin
         miscompares++;
         $display("FAIL full_ignore: got count=%0d required 4", count);
      end
      regA = 5'd1;
      regB = 5'd7;
      #1;
      vectors++;
      if ({hitA, fwdA, hitB, fwdB} !== {1'b1, 32'h33, 1'b0, 32'h0}) begin
         miscompares++;
         $display("FAIL bypass_youngest: got %b/%h %b/%h required 1/33 0/0", hitA, fwdA, hitB, fwdB);
      end
      regB = 5'd2;
      #1;
      vectors++;
      if ({hitB, fwdB} !== {1'b1, 32'h22}) begin
         miscompares++;
         $display("FAIL bypass_b: got %b/%h required 1/22", hitB, fwdB);
      end
   endtask

   task automatic test_drain_order();
      drain_en = 1'b1;
      tick();
      vectors++;
      if (count !== 3'd3) begin
         miscompares++;
         $display("FAIL drain_count: got %0d required 3", count);
      end
      tick();
      vectors++;
      if ({hitA, fwdA} !== {1'b1, 32'h33}) begin
         miscompares++;
         $display("FAIL bypass_head: got %b/%h required 1/33", hitA, fwdA);
      end
      tick();
      vectors++;
      if ({hitA, fwdA} !== {1'b0, 32'h0}) begin
         miscompares++;
         $display("FAIL bypass_after_pop: got %b/%h required 0/0", hitA, fwdA);
      end
      tick();
      vectors++;
      if ({empty, exp_q.size() == 0} !== 2'b11) begin
         miscompares++;
         $display("FAIL drain_empty: got empty=%b pending=%0d required 1/0", empty, exp_q.size());
      end
   endtask

   task automatic test_back_to_back();
      drain_en = 1'b0;
      push(5'd10, 32'h100);
      push(5'd11, 32'h101);
      drain_en = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_addr = AW'(12 + i);
         in_data = 32'h200 + DW'(i);
         tick();
         vectors++;
         if (count !== 3'd2) begin
            miscompares++;
            $display("FAIL b2b_count: cycle %0d got %0d required 2", i, count);
         end
      end
      in_valid = 1'b0;
      for (int k = 0; k < 10 && !empty; k++) tick();
      vectors++;
      if ({empty, exp_q.size() == 0} !== 2'b11) begin
         miscompares++;
         $display("FAIL b2b_empty: got empty=%b pending=%0d required 1/0", empty, exp_q.size());
      end
   endtask

   task automatic test_async_reset();
      drain_en = 1'b0;
      push(5'd20, 32'h300);
      push(5'd21, 32'h301);
      push(5'd22, 32'h302);
      regA = 5'd21;
      drain_en = 1'b1;
      #1 rst = 1'b0;
      #1;
      vectors++;
      if ({count, empty, in_ready, RegWrite, hitA, fwdA, regW, Wdat} !==
          {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0}) begin
         miscompares++;
         $display("FAIL async_reset: count=%0d empty=%b rdy=%b RegWrite=%b hitA=%b fwdA=%h regW=%0d Wdat=%h required 0/1/1/0/0/0/0/0",
                  count, empty, in_ready, RegWrite, hitA, fwdA, regW, Wdat);
      end
      exp_q.delete();
      mdl_count = 0;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      vectors++;
      if ({RegWrite, empty} !== 2'b01) begin
         miscompares++;
         $display("FAIL post_reset_idle: got RegWrite=%b empty=%b required 0/1", RegWrite, empty);
      end
   endtask

   task automatic test_index0();
      drain_en = 1'b1;
      regA = 5'd0;
      push(5'd0, 32'hDEAD_BEEF);
      vectors++;
      if ({RegWrite, regW, Wdat, hitA, fwdA} !== {1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF}) begin
         miscompares++;
         $display("FAIL index0: got %b/%0d/%h hit %b/%h required 1/0/deadbeef hit 1/deadbeef", RegWrite, regW, Wdat, hitA, fwdA);
      end
      tick();
      vectors++;
      if (empty !== 1'b1) begin
         miscompares++;
         $display("FAIL index0_drained: got empty=%b required 1", empty);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_drain_order();
      test_back_to_back();
      test_async_reset();
      test_index0();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regfile_wr_buffer.md
Name: regfile_wr_buffer

Overview:
- Write-side companion to the 32x32 register file. It accepts write-back results (destination index and data) from the pipeline and stores them in a small in-order FIFO.
- It drains one entry per cycle onto the register file write port (RegWrite/regW/Wdat). The register file commits that write on the falling clock edge.
- It also provides read-bypass lookup. Decode can fetch the youngest pending value for regA/regB before that value reaches the register file.

Parameters:
- DEPTH, 4, number of buffer entries; must be a power of 2, minimum 2.
- AW, 5, register index width.
- DW, 32, data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer presents a write-back result.
- in_ready  output  1  buffer can accept; equals not full.
- in_addr  input  AW  destination register index.
- in_data  input  DW  result data.
- drain_en  input  1  high permits the head entry to be issued to the register file.
- RegWrite  output  1  write strobe to the register file.
- regW  output  AW  write index to the register file.
- Wdat  output  DW  write data to the register file.
- regA  input  AW  lookup index A.
- regB  input  AW  lookup index B.
- hitA  output  1  a pending entry matches regA.
- hitB  output  1  a pending entry matches regB.
- fwdA  output  DW  youngest pending data for regA.
- fwdB  output  DW  youngest pending data for regB.
- count  output  log2(DEPTH)+1  number of occupied entries.
- empty  output  1  count == 0.

Behaviour:
- Reset (rst low, asynchronous):
  - Pointers and count go to 0; all entry valid bits clear.
  - in_ready=1, empty=1, RegWrite=0, hitA=hitB=0.
  - regW, Wdat, fwdA and fwdB read 0 while no entry is valid.
  - Reset asserted mid-operation discards all pending entries; no partial write is issued afterwards.
- Storage: circular FIFO with wr_ptr and rd_ptr, each log2(DEPTH) bits and wrapping modulo DEPTH, plus a count register.
- Push:
  - Occurs on a rising edge when in_valid && in_ready.
  - Entry[wr_ptr] takes {in_addr, in_data}; its valid bit sets; wr_ptr increments.
  - in_ready = (count != DEPTH), driven combinationally from count.
- Write port:
  - RegWrite = !empty && drain_en, combinational.
  - regW and Wdat show the head entry; they are 0 when empty.
  - The register file samples these on the falling edge of the same cycle.
- Pop:
  - Occurs on a rising edge when RegWrite is 1.
  - The head valid bit clears and rd_ptr increments.
  - Each entry is written to the register file exactly once.
- Latency:
  - A result pushed at rising edge N is visible on the write port in cycle N, at the earliest.
  - With drain_en held high, it is committed to the register file at the falling edge of cycle N and popped at edge N+1.
  - There is no same-cycle pass-through from the in_* inputs to the write port.
- Simultaneous push and pop:
  - Allowed when not full; count is unchanged and both pointers advance.
  - When full, in_ready=0 even if a pop occurs in the same cycle.
- Full/empty:
  - count == DEPTH means full; a push request is ignored and the producer must hold its inputs.
  - A pop request while empty is impossible because RegWrite=0.
- Ordering: writes leave in arrival order, including multiple writes to the same index.
- Bypass lookup:
  - Combinational; compares regA and regB against all valid entries.
  - hitX = 1 if any valid entry's address equals regX.
  - fwdX = data of the youngest matching entry, i.e. the nearest entry behind wr_ptr.
  - fwdX = 0 when there is no hit.
  - The head entry being written this cycle still counts as a hit until it is popped.
  - The in_* inputs are not searched.
- Index 0 is an ordinary writable register in this register file; there is no special-casing.
- count is updated as count + push - pop and never exceeds DEPTH.

Test Plan:
1. Reset, drain_en=1, push (3, 0x000000AA) -> next cycle RegWrite=1, regW=3, Wdat=0xAA. Following edge: empty=1, RegWrite=0.
2. drain_en=0, push 4 entries (1,0x11), (2,0x22), (1,0x33), (5,0x55) -> count=4, in_ready=0. Fifth push is ignored. regA=1 gives hitA=1, fwdA=0x33. regB=7 gives hitB=0, fwdB=0.
3. From state 2, raise drain_en -> writes issue in order over 4 cycles: (1,0x11), (2,0x22), (1,0x33), (5,0x55). After the (1,0x33) pop, regA=1 gives hitA=0.
4. Buffer at count=2 with drain_en=1 and in_valid=1 every cycle for 8 cycles -> count stays 2. Pointers wrap past DEPTH with no loss, and the write order matches the push order.
5. Pulse rst low asynchronously mid-cycle with 3 entries pending -> outputs go to reset values immediately. No RegWrite occurs afterwards until a new push.
6. Push (0, 0xDEADBEEF) -> RegWrite=1, regW=0, Wdat=0xDEADBEEF. Index 0 is not suppressed.
